// File: rtl/pulse_measure_pkg.sv
// pulse_measure_pkg
// Shared types and helpers for the pulse_measure receive-side checker.
//   state_t  : measurement FSM state (IDLE waits for the first edge, MEAS runs)
//   cnt_t    : default-width measurement counter (DEFAULT_CNT_W bits)
//   sat_inc  : saturating increment for a counter of any width up to 32 bits
package pulse_measure_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // Counters narrower than 32 bits are zero-extended by the caller and the
  // result truncated back, so one helper serves every counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/pulse_measure_if.sv
// pulse_measure_if
// Result bundle produced by pulse_measure.
//   o_valid        : one-cycle strobe, new measurement on o_duration/o_period
//   o_duration     : last measured high time (CNT_W bits)
//   o_period       : last measured rising-edge-to-rising-edge time (CNT_W bits)
//   o_err_duration : last duration differed from the expected value
//   o_err_period   : last period differed from the expected value
//   o_locked       : enough consecutive good measurements seen
//   o_timeout      : one-cycle strobe, no rising edge within the timeout window
//   dbg_state      : current FSM state, for observation only
// Handshake: o_valid is a valid-only strobe with no ready; the consumer must
// take o_duration/o_period/o_err_* in the cycle o_valid is high. Those values
// stay stable until the next o_valid, so late sampling is also safe.
interface pulse_measure_if #(
  parameter int CNT_W = 16
);
  import pulse_measure_pkg::*;

  logic             o_valid;
  logic [CNT_W-1:0] o_duration;
  logic [CNT_W-1:0] o_period;
  logic             o_err_duration;
  logic             o_err_period;
  logic             o_locked;
  logic             o_timeout;
  state_t           dbg_state;

  modport master (
    output o_valid, o_duration, o_period, o_err_duration, o_err_period,
           o_locked, o_timeout, dbg_state
  );

  modport slave (
    input o_valid, o_duration, o_period, o_err_duration, o_err_period,
          o_locked, o_timeout, dbg_state
  );

endinterface

// File: rtl/pulse_edge_detect.sv
// pulse_edge_detect
// Registers the previous pulse sample and flags edges on the current sample.
//   clk     : system clock
//   rst     : synchronous active-low reset (previous sample forced to 0)
//   i_pulse : pulse input, synchronous to clk
//   rise    : i_pulse high now, low on the previous cycle
//   fall    : i_pulse low now, high on the previous cycle
// Because the previous sample resets to 0, a high input at reset release is
// reported as a rising edge.
module pulse_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_pulse,
  output logic rise,
  output logic fall
);

  logic p_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q <= 1'b0;
    end else begin
      p_q <= i_pulse;
    end
  end

  assign rise = i_pulse & ~p_q;
  assign fall = ~i_pulse & p_q;

endmodule

// File: rtl/pulse_measure.sv
// pulse_measure
// Receive-side checker for a pulse train: measures high time and period in
// clk cycles, flags deviations from PULSE_DURATION / PULSE_PERIOD and
// declares lock after LOCK_COUNT consecutive good measurements.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   i_pulse : pulse train, synchronous to clk
//   m       : pulse_measure_if.master result bundle (see interface header)
// Optional feature: define PULSE_MEASURE_TIMEOUT_EN to abort a measurement
// whose period counter reaches 2*PULSE_PERIOD without a rising edge (pulses
// o_timeout, drops lock, returns to IDLE). Without it o_timeout stays 0 and
// the counters simply saturate.
module pulse_measure #(
  parameter int PULSE_DURATION = 2,
  parameter int PULSE_PERIOD   = 3,
  parameter int LOCK_COUNT     = 4,
  parameter int CNT_W          = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pulse,
  pulse_measure_if.master m
);
  import pulse_measure_pkg::*;

  // sat_inc works on 32-bit values, which bounds the counter width.
  if (PULSE_DURATION < 1 || PULSE_PERIOD < 1 || LOCK_COUNT < 1 || CNT_W < 1 ||
      CNT_W > 32 || PULSE_DURATION > PULSE_PERIOD) begin : g_bad_params
    $fatal(1, "pulse_measure: illegal parameter combination");
  end

  // A constant-high train has no rising edges after the first one, so the
  // period boundary has to be synthesised from the counter.
  localparam bit               CONST_HIGH = (PULSE_DURATION == PULSE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_CNT    = CNT_W'(PULSE_PERIOD);
  localparam logic [31:0]      LOCK_MAX   = 32'(LOCK_COUNT);

  logic rise;
  logic fall;

  pulse_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_pulse (i_pulse),
    .rise    (rise),
    .fall    (fall)
  );

  state_t           state_q;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] dur_cnt;
  logic             high_q;      // still inside the high phase since the last rise
  logic             valid_q;
  logic [CNT_W-1:0] dur_q;
  logic [CNT_W-1:0] per_q;
  logic             err_dur_q;
  logic             err_per_q;
  logic [31:0]      good_cnt;
  logic             locked_q;
  logic             timeout_q;

  logic             synth;
  logic             tmo_hit;
  logic [CNT_W-1:0] rep_dur;
  logic [CNT_W-1:0] rep_per;
  logic             rep_err_dur;
  logic             rep_err_per;
  logic [31:0]      good_next;

  // Value published on a measurement boundary, whether from a real rising
  // edge or from the synthetic constant-high boundary.
  always_comb begin
    synth = 1'b0;
    if (CONST_HIGH) begin
      synth = (state_q == MEAS) && !rise && i_pulse && (period_cnt == PER_CNT);
    end
    rep_dur     = synth ? PER_CNT : dur_cnt;
    rep_per     = synth ? PER_CNT : period_cnt;
    // A saturated count never represents a true measurement.
    rep_err_dur = (32'(rep_dur) != 32'(PULSE_DURATION)) || (rep_dur == CNT_MAX);
    rep_err_per = (32'(rep_per) != 32'(PULSE_PERIOD)) || (rep_per == CNT_MAX);
    if (rep_err_dur || rep_err_per) begin
      good_next = 32'd0;
    end else if (good_cnt >= LOCK_MAX) begin
      good_next = LOCK_MAX;
    end else begin
      good_next = good_cnt + 32'd1;
    end
  end

`ifdef PULSE_MEASURE_TIMEOUT_EN
  assign tmo_hit = (state_q == MEAS) && !rise && !synth &&
                   (32'(period_cnt) == 32'(2 * PULSE_PERIOD));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      period_cnt <= '0;
      dur_cnt    <= '0;
      high_q     <= 1'b0;
      valid_q    <= 1'b0;
      dur_q      <= '0;
      per_q      <= '0;
      err_dur_q  <= 1'b0;
      err_per_q  <= 1'b0;
      good_cnt   <= 32'd0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (fall) begin
        high_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rise) begin
            period_cnt <= CNT_ONE;
            dur_cnt    <= CNT_ONE;
            high_q     <= 1'b1;
            state_q    <= MEAS;
          end
        end
        MEAS: begin
          // Edge beats saturation and timeout: the saturated values are
          // still reported and flagged.
          if (rise || synth) begin
            valid_q    <= 1'b1;
            dur_q      <= rep_dur;
            per_q      <= rep_per;
            err_dur_q  <= rep_err_dur;
            err_per_q  <= rep_err_per;
            good_cnt   <= good_next;
            locked_q   <= (good_next == LOCK_MAX);
            period_cnt <= CNT_ONE;
            dur_cnt    <= CNT_ONE;
            high_q     <= 1'b1;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            good_cnt  <= 32'd0;
            locked_q  <= 1'b0;
            state_q   <= IDLE;
          end else begin
            period_cnt <= CNT_W'(sat_inc(32'(period_cnt), CNT_W));
            if (i_pulse && high_q) begin
              dur_cnt <= CNT_W'(sat_inc(32'(dur_cnt), CNT_W));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m.o_valid        = valid_q;
  assign m.o_duration     = dur_q;
  assign m.o_period       = per_q;
  assign m.o_err_duration = err_dur_q;
  assign m.o_err_period   = err_per_q;
  assign m.o_locked       = locked_q;
  assign m.o_timeout      = timeout_q;
  assign m.dbg_state      = state_q;

endmodule
